dmem_arbiter: RTL

Two-port arbiter and sequencer in front of the single-port data memory (`mem`). It accepts load/store requests from two requesters: port 0 is the pipeline MEM stage and port 1 is the debug/loader port. It grants one request at a time and drives the memory's address, write-data, `MemWrite` and `MemRead` inputs. It returns a registered read result with a one-cycle acknowledge and flags out-of-range word addresses instead of corrupting memory.

---
 rtl/dmem_arbiter_if.sv | 43 ++++
 rtl/dmem_arbiter.sv | 123 ++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_if
// Brief    : Requester and memory-side bundle for the dmem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic              err0;
  logic              err1;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_write;
  logic              mem_read;
  logic [DATA_W-1:0] mem_data_out;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
    output ack0, ack1, err0, err1, rdata, busy,
           mem_address, mem_data_in, mem_write, mem_read
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
    input  ack0, ack1, err0, err1, rdata, busy,
           mem_address, mem_data_in, mem_write, mem_read
  );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Two-port arbiter/sequencer in front of the single-port data
//            memory. Define DMEM_ARB_RR_EN for round-robin arbitration,
//            otherwise port 0 has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 64,
  parameter int DEPTH_W = 10
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_id;
  logic              r_we;
  logic              r_oor;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;

  logic              w_any_req;
  logic              w_grant;
  logic              w_grant_id;
  logic [ADDR_W-1:0] w_grant_addr;
  logic              w_grant_oor;

  assign w_any_req = bus.req0 | bus.req1;
  assign w_grant   = (r_state == IDLE) && w_any_req;

`ifdef DMEM_ARB_RR_EN
  logic r_last_id;

  // On a collision the port that did not win last time goes first.
  always_comb begin
    if (bus.req0 && bus.req1) begin
      w_grant_id = ~r_last_id;
    end else begin
      w_grant_id = ~bus.req0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_id <= 1'b1;
    end else if (w_grant) begin
      r_last_id <= w_grant_id;
    end
  end
`else
  assign w_grant_id = ~bus.req0;
`endif

  assign w_grant_addr = w_grant_id ? bus.addr1 : bus.addr0;
  // Full-width check so large addresses never alias into the array.
  assign w_grant_oor  = (w_grant_addr >> DEPTH_W) != '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any_req) w_state_nxt = ACCESS;
      ACCESS:  w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_id    <= 1'b0;
      r_we    <= 1'b0;
      r_oor   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (w_grant) begin
        r_id    <= w_grant_id;
        r_we    <= w_grant_id ? bus.we1 : bus.we0;
        r_addr  <= w_grant_addr;
        r_wdata <= w_grant_id ? bus.wdata1 : bus.wdata0;
        r_oor   <= w_grant_oor;
      end
      if ((r_state == ACCESS) && !r_we) begin
        r_rdata <= r_oor ? '0 : bus.mem_data_out;
      end
    end
  end

  assign bus.ack0        = (r_state == DONE) & ~r_id;
  assign bus.ack1        = (r_state == DONE) &  r_id;
  assign bus.err0        = bus.ack0 & r_oor;
  assign bus.err1        = bus.ack1 & r_oor;
  assign bus.rdata       = r_rdata;
  assign bus.busy        = (r_state != IDLE);
  assign bus.mem_address = r_addr;
  assign bus.mem_data_in = r_wdata;
  // Reset gates the write strobe combinationally so an aborted store never lands.
  assign bus.mem_write   = (r_state == ACCESS) & r_we & ~r_oor & ~reset;
  assign bus.mem_read    = (r_state == ACCESS) & ~r_we & ~r_oor;

endmodule
`default_nettype wire
